mips_alu_md: RTL and testbench

Parametrised registered ALU with an integrated iterative multiply/divide unit and HI/LO registers, for the MIPS32 datapath execute stage.
- Single-cycle integer ops return a registered result one cycle after issue.
- MULT/MULTU/DIV/DIVU run sequentially over WIDTH cycles and write HI/LO. MFHI/MFLO/MTHI/MTLO access HI/LO.
- A valid/ready issue handshake lets the control FSM stall while the multiply/divide unit is busy.

---
 rtl/mips_alu_md.sv | 250 +++++++++++++++++++++++++
 tb/tb_mips_alu_md.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_md.sv
// mips_alu_md: registered MIPS32 execute-stage ALU with an iterative
// multiply/divide unit and architectural HI/LO registers.
// Build option: define ALU_FAST_MUL_EN to make MULT/MULTU complete in a
// single cycle from a combinational product. DIV/DIVU stay iterative.
module mips_alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sa,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_SLLV  = 5'd9;
  localparam logic [4:0] OP_SRLV  = 5'd10;
  localparam logic [4:0] OP_SRAV  = 5'd11;
  localparam logic [4:0] OP_LUI   = 5'd12;
  localparam logic [4:0] OP_SLTU  = 5'd13;
  localparam logic [4:0] OP_PASSA = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MTLO  = 5'd23;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             out_valid_q, out_valid_d;

  // Shadow state of the iterative unit: sh_hi is the partial product /
  // partial remainder, sh_lo the multiplier / dividend-quotient shift
  // register, sh_b the multiplicand / divisor magnitude.
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d;
  logic [WIDTH-1:0] sh_lo_q, sh_lo_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             start_md;
  logic             sgn;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mstep_hi, mstep_lo;
  logic [WIDTH:0]   dtrial;
  logic             dge;
  logic [WIDTH-1:0] dstep_hi, dstep_lo;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_s, fast_u;
  assign fast_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign fast_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  // Magnitude of an operand when it is treated as signed.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  // Single-cycle integer operations.
  function automatic logic [WIDTH-1:0] alu_f(input logic [4:0] o,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [SHW-1:0] s);
    logic [SHW-1:0] vs;
    vs = x[SHW-1:0];
    case (o)
      OP_AND:   return x & y;
      OP_OR:    return x | y;
      OP_ADD:   return x + y;
      OP_SUB:   return x - y;
      OP_SLT:   return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_XOR:   return x ^ y;
      OP_SLL:   return y << s;
      OP_SRL:   return y >> s;
      OP_SRA:   return $unsigned($signed(y) >>> s);
      OP_SLLV:  return y << vs;
      OP_SRLV:  return y >> vs;
      OP_SRAV:  return $unsigned($signed(y) >>> vs);
      OP_LUI:   return {y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLTU:  return {{(WIDTH-1){1'b0}}, (x < y)};
      OP_PASSA: return x;
      default:  return '0;
    endcase
  endfunction

  assign busy      = (state_q == RUN);
  assign in_ready  = !busy && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // One iteration of shift-add multiply or restoring divide, plus the
  // sign fix-up applied to the final iteration's values at commit.
  always_comb begin
    msum     = {1'b0, sh_hi_q} + (sh_lo_q[0] ? {1'b0, sh_b_q} : '0);
    mstep_hi = msum[WIDTH:1];
    mstep_lo = {msum[0], sh_lo_q[WIDTH-1:1]};
    dtrial   = {sh_hi_q, sh_lo_q[WIDTH-1]};
    dge      = (dtrial >= {1'b0, sh_b_q});
    dstep_hi = dtrial[WIDTH-1:0] - (dge ? sh_b_q : '0);
    dstep_lo = {sh_lo_q[WIDTH-2:0], dge};
    step_hi  = is_div_q ? dstep_hi : mstep_hi;
    step_lo  = is_div_q ? dstep_lo : mstep_lo;
    prod     = {step_hi, step_lo};
    prod_fix = neg_lo_q ? -prod : prod;
  end

  // Issue decode, FSM next state and HI/LO/result updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    sh_hi_d     = sh_hi_q;
    sh_lo_d     = sh_lo_q;
    sh_b_d      = sh_b_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    dz_d        = dz_q;
    start_md    = 1'b0;
    sgn         = (op == OP_MULT) || (op == OP_DIV);

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_SLL, OP_SRL,
            OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI, OP_SLTU, OP_PASSA: begin
              result_d    = alu_f(op, a, b, sa);
              out_valid_d = 1'b1;
            end
            OP_MFHI: begin
              result_d    = hi_q;
              out_valid_d = 1'b1;
            end
            OP_MFLO: begin
              result_d    = lo_q;
              out_valid_d = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef ALU_FAST_MUL_EN
            OP_MULT:  {hi_d, lo_d} = fast_s;
            OP_MULTU: {hi_d, lo_d} = fast_u;
            OP_DIV, OP_DIVU: start_md = 1'b1;
`else
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_md = 1'b1;
`endif
            default: ;
          endcase
        end
        if (start_md) begin
          state_d  = RUN;
          cnt_d    = SHW'(WIDTH - 1);
          is_div_d = (op == OP_DIV) || (op == OP_DIVU);
          sh_hi_d  = '0;
          sh_lo_d  = mag_f(a, sgn);
          sh_b_d   = mag_f(b, sgn);
          neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d = sgn && a[WIDTH-1];
          dz_d     = (b == '0);
        end
      end
      RUN: begin
        sh_hi_d = step_hi;
        sh_lo_d = step_lo;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (is_div_q) begin
            lo_d = dz_q ? '1 : (neg_lo_q ? -step_lo : step_lo);
            hi_d = neg_hi_q ? -step_hi : step_hi;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural state; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Iterative-unit shadow datapath; only meaningful while in RUN.
  always_ff @(posedge clk) begin
    sh_hi_q  <= sh_hi_d;
    sh_lo_q  <= sh_lo_d;
    sh_b_q   <= sh_b_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    dz_q     <= dz_d;
  end

endmodule

// File: tb/tb_mips_alu_md.sv
// Testbench for mips_alu_md (WIDTH=32): table of single-cycle vectors plus
// hand-written multiply/divide, stall, reset and HI/LO sequences.
module tb_mips_alu_md;
  localparam int W   = 32;
  localparam int SHW = 5;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [4:0]     op;
  logic [W-1:0]   a, b;
  logic [SHW-1:0] sa;
  logic           out_valid;
  logic [W-1:0]   result;
  logic           zero;
  logic           busy;
  logic [W-1:0]   hi, lo;

  mips_alu_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .sa(sa), .out_valid(out_valid), .result(result),
    .zero(zero), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ALU_FAST_MUL_EN
  localparam logic [4:0] RUN_OP = 5'd19;
  localparam logic [W-1:0] RUN_HI = 32'h0;
  localparam logic [W-1:0] RUN_LO = 32'h3;
`else
  localparam logic [4:0] RUN_OP = 5'd17;
  localparam logic [W-1:0] RUN_HI = 32'h0;
  localparam logic [W-1:0] RUN_LO = 32'h4B;
`endif

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sa;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [4:0] s);
    @(negedge clk);
    op = o; a = x; b = y; sa = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic md_run(input string name, input logic [4:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    logic [W-1:0] h0, l0;
    logic         changed;
    int           k;
    bit           fast;
    fast = 1'b0;
`ifdef ALU_FAST_MUL_EN
    fast = (o == 5'd16) || (o == 5'd17);
`endif
    drive(o, x, y, 5'd0);
    if (fast) begin
      chk({name, "_busy"}, busy, 0);
    end else begin
      chk({name, "_busy"}, busy, 1);
      chk({name, "_rdy"}, in_ready, 0);
      h0 = hi; l0 = lo; changed = 1'b0; k = 0;
      do begin
        @(posedge clk);
        #1;
        k++;
        if (busy && (hi !== h0 || lo !== l0)) changed = 1'b1;
      end while (busy && k < 100);
      chk({name, "_cycles"}, k, W);
      chk({name, "_hold"}, changed, 0);
    end
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int k;
    logic seen_ov, seen_rdy;

    vecs[0]  = '{5'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0};
    vecs[1]  = '{5'd3,  32'h12345678, 32'h12345678, 5'd0,  32'h00000000, 1'b1};
    vecs[2]  = '{5'd11, 32'h00000021, 32'h80000000, 5'd0,  32'hC0000000, 1'b0};
    vecs[3]  = '{5'd12, 32'h00000000, 32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0};
    vecs[4]  = '{5'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0};
    vecs[5]  = '{5'd1,  32'h0F0F0000, 32'h000000FF, 5'd0,  32'h0F0F00FF, 1'b0};
    vecs[6]  = '{5'd5,  32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 1'b0};
    vecs[7]  = '{5'd4,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
    vecs[8]  = '{5'd13, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
    vecs[9]  = '{5'd6,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
    vecs[10] = '{5'd7,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0};
    vecs[11] = '{5'd8,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
    vecs[12] = '{5'd9,  32'h00000024, 32'h0000000F, 5'd0,  32'h000000F0, 1'b0};
    vecs[13] = '{5'd10, 32'hFFFFFFE4, 32'hF0000000, 5'd0,  32'h0F000000, 1'b0};
    vecs[14] = '{5'd14, 32'h13579BDF, 32'h00000000, 5'd0,  32'h13579BDF, 1'b0};
    vecs[15] = '{5'd2,  32'hFFFFFFFF, 32'h00000002, 5'd0,  32'h00000001, 1'b0};
    vecs[16] = '{5'd3,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0};

    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; sa = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), zero, vecs[i].z);
      chk($sformatf("vec%0d_ov", i), out_valid, 1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ov_drop", i), out_valid, 0);
    end

    md_run("mult_neg", 5'd16, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB);
    drive(5'd21, '0, '0, 5'd0);
    chk("mflo_after_mult", result, 32'hFFFFFFEB);
    chk("mflo_after_mult_ov", out_valid, 1);
    md_run("multu_max", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    md_run("mult_minsq", 5'd16, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    md_run("div_neg", 5'd18, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("divu_by0", 5'd19, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    md_run("div_ovf", 5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    md_run("divu_100_7", 5'd19, 32'd100, 32'd7, 32'd2, 32'd14);
    md_run("div_neg_by0", 5'd18, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    md_run("div_pos_negd", 5'd18, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // Held request during RUN: operands change after accept, ADD waits.
    drive(RUN_OP, 32'd15, 32'd5, 5'd0);
    op = 5'd2; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    k = 0; seen_ov = 1'b0; seen_rdy = 1'b0;
    while (busy && k < 100) begin
      if (in_ready) seen_rdy = 1'b1;
      @(posedge clk);
      #1;
      k++;
      if (out_valid) seen_ov = 1'b1;
    end
    chk("held_cycles", k, W);
    chk("held_no_ready", seen_rdy, 0);
    chk("held_no_ov", seen_ov, 0);
    chk("held_run_hi", hi, RUN_HI);
    chk("held_run_lo", lo, RUN_LO);
    chk("held_ready_now", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("held_add_ov", out_valid, 1);
    chk("held_add_result", result, 3);

    // Reset ten cycles into a run.
    drive(RUN_OP, 32'hFFFFFFFF, 32'h00000003, 5'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy_before", busy, 1);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    // HI/LO moves and an undefined op code.
    drive(5'd22, 32'hDEADBEEF, '0, 5'd0);
    chk("mthi_ov", out_valid, 0);
    chk("mthi_result_hold", result, 0);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    drive(5'd23, 32'hCAFEF00D, '0, 5'd0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    drive(5'd20, '0, '0, 5'd0);
    chk("mfhi_result", result, 32'hDEADBEEF);
    chk("mfhi_ov", out_valid, 1);
    drive(5'd21, '0, '0, 5'd0);
    chk("mflo_result", result, 32'hCAFEF00D);
    drive(5'd15, 32'h1, 32'h1, 5'd0);
    chk("op15_ov", out_valid, 0);
    chk("op15_result", result, 32'hCAFEF00D);
    chk("op15_hi", hi, 32'hDEADBEEF);
    chk("op15_lo", lo, 32'hCAFEF00D);
    chk("op15_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
